// File: rtl/ula_driver_if.sv
// Command, response and ULA-side signals of ula_driver.
// The driver uses the slave modport; the command source/consumer uses master.
interface ula_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_sel;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic [2:0] cmd_exp;
  logic       cmd_chk;

  logic [3:0] ula_sel;
  logic [1:0] ula_a;
  logic [1:0] ula_b;
  logic [2:0] ula_saida;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_saida;
  logic       rsp_err;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_exp, cmd_chk,
    input  ula_saida, rsp_ready,
    output cmd_ready, ula_sel, ula_a, ula_b,
    output rsp_valid, rsp_saida, rsp_err
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_exp, cmd_chk,
    output ula_saida, rsp_ready,
    input  cmd_ready, ula_sel, ula_a, ula_b,
    input  rsp_valid, rsp_saida, rsp_err
  );
endinterface

// File: rtl/ula_driver.sv
// Command-driven initiator for the 4-bit-select ULA: drives operands, waits
// ULA_LAT cycles, captures Saida, optionally checks it and returns a response.
module ula_driver #(
  parameter int ULA_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ula_driver_if.slave      bus,
  output logic [CNT_W-1:0] o_op_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int WCW = (ULA_LAT > 1) ? $clog2(ULA_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_wait_done;
  logic             w_rsp_fire;

  logic [WCW-1:0]   r_wait_cnt;
  logic [3:0]       r_ula_sel;
  logic [1:0]       r_ula_a;
  logic [1:0]       r_ula_b;
  logic [2:0]       r_exp;
  logic             r_chk;
  logic             r_rsp_valid;
  logic [2:0]       r_rsp_saida;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_err_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_W'(1'b1);
    end
  endfunction

  function automatic logic chk_fail(input logic chk, input logic [2:0] saida,
                                    input logic [2:0] exp);
    chk_fail = chk && (saida != exp);
  endfunction

  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == {WCW{1'b0}});
  assign w_rsp_fire  = r_rsp_valid && bus.rsp_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_wait_done) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_rsp_fire) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs; ready is forced low while reset is held.
  always_comb begin
    w_cmd_ready = 1'b0;
    if ((r_state == ST_IDLE) && !i_rst) begin
      w_cmd_ready = 1'b1;
    end else begin
      w_cmd_ready = 1'b0;
    end
  end

  // Operand drive, latency counter and response capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ula_sel   <= 4'd0;
      r_ula_a     <= 2'd0;
      r_ula_b     <= 2'd0;
      r_exp       <= 3'd0;
      r_chk       <= 1'b0;
      r_wait_cnt  <= {WCW{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_saida <= 3'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ula_sel  <= bus.cmd_sel;
        r_ula_a    <= bus.cmd_a;
        r_ula_b    <= bus.cmd_b;
        r_exp      <= bus.cmd_exp;
        r_chk      <= bus.cmd_chk;
        r_wait_cnt <= WCW'(ULA_LAT - 1);
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != {WCW{1'b0}})) begin
        r_wait_cnt <= r_wait_cnt - WCW'(1'b1);
      end
      // Saida is sampled exactly once; later changes on it are ignored.
      if (w_wait_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_saida <= bus.ula_saida;
        r_rsp_err   <= chk_fail(r_chk, bus.ula_saida, r_exp);
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Saturating operation and error counters, stepped on response handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_count  <= {CNT_W{1'b0}};
      r_err_count <= {CNT_W{1'b0}};
    end else if (w_rsp_fire) begin
      r_op_count <= sat_inc(r_op_count);
      if (r_rsp_err) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.ula_sel   = r_ula_sel;
  assign bus.ula_a     = r_ula_a;
  assign bus.ula_b     = r_ula_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_saida = r_rsp_saida;
  assign bus.rsp_err   = r_rsp_err;
  assign o_op_count    = r_op_count;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_ula_driver.sv
// Self-checking bench for ula_driver: three instances (ULA_LAT=1, ULA_LAT=3,
// CNT_W=2) in front of a behavioural ULA stand-in, with a response scoreboard.
module tb_ula_driver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] saida;
    logic       err;
  } exp_t;
  exp_t sb[$];

  ula_driver_if bus();
  ula_driver_if bus3();
  ula_driver_if bus2();

  logic [7:0] op_cnt, err_cnt, op_cnt3, err_cnt3;
  logic [1:0] op_cnt2, err_cnt2;
  logic [2:0] noise;

  // Stand-in ULA: only the operations the scenarios use are meaningful.
  function automatic logic [2:0] ula_f(input logic [3:0] sel, input logic [1:0] a,
                                       input logic [1:0] b);
    case (sel)
      4'b0000: ula_f = {1'b0, a} + {2'b00, b[0]};
      4'b0010: ula_f = {1'b0, a | {1'b0, b[0]}};
      4'b0011: ula_f = {1'b0, a} - {2'b00, b[0]};
      4'b0100: ula_f = {a, 1'b0};
      4'b1110: ula_f = {2'b00, a == b};
      4'b1111: ula_f = {2'b00, a != b};
      default: ula_f = {1'b0, a};
    endcase
  endfunction

  assign bus.ula_saida  = ula_f(bus.ula_sel, bus.ula_a, bus.ula_b) ^ noise;
  assign bus2.ula_saida = ula_f(bus2.ula_sel, bus2.ula_a, bus2.ula_b);

  // Two register stages: with ULA_LAT=3 the result is valid only at edge N+3.
  logic [2:0] d1, d2;
  always @(posedge clk) begin
    d1 <= ula_f(bus3.ula_sel, bus3.ula_a, bus3.ula_b);
    d2 <= d1;
  end
  assign bus3.ula_saida = d2;

  ula_driver #(.ULA_LAT(1), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_op_count(op_cnt), .o_err_count(err_cnt));
  ula_driver #(.ULA_LAT(3), .CNT_W(8)) dut3 (
    .i_clk(clk), .i_rst(rst), .bus(bus3), .o_op_count(op_cnt3), .o_err_count(err_cnt3));
  ula_driver #(.ULA_LAT(1), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2), .o_op_count(op_cnt2), .o_err_count(err_cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] sel, input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] exp, input logic chk,
                      input logic [2:0] es, input logic ee, output int t_acc);
    bit ok = 1'b0;
    bus.cmd_sel = sel; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_exp = exp; bus.cmd_chk = chk; bus.cmd_valid = 1'b1;
    t_acc = cyc;
    for (int n = 0; n < 20; n++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        tick();
        t_acc = cyc;
        break;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    sb.push_back('{saida: es, err: ee});
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept_timeout: got no accept, expected accept within 20 cycles");
    end
  endtask

  task automatic wait_rsp(input int t_acc, output logic [2:0] s, output logic e,
                          output int lat);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (bus.rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    lat = cyc - t_acc;
    s = bus.rsp_saida;
    e = bus.rsp_err;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected rsp_valid within 50 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_ready: got %0b expected 0", bus.cmd_ready);
    end
    checks++;
    if ({bus.ula_sel, bus.ula_a, bus.ula_b, bus.rsp_saida, bus.rsp_valid, bus.rsp_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%0h a=%0h b=%0h saida=%0h v=%0b e=%0b expected all 0",
               bus.ula_sel, bus.ula_a, bus.ula_b, bus.rsp_saida, bus.rsp_valid, bus.rsp_err);
    end
    checks++;
    if (op_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", op_cnt, err_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL idle_cmd_ready: got %0b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_add();
    int t, lat;
    logic [2:0] s;
    logic e;
    exp_t x;
    send(4'b0000, 2'b10, 2'b01, 3'b011, 1'b1, 3'b011, 1'b0, t);
    checks++;
    if ({bus.ula_sel, bus.ula_a, bus.ula_b} !== {4'b0000, 2'b10, 2'b01} || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_ula_drive: got sel=%0b a=%0b b=%0b rdy=%0b expected 0000/10/01/0",
               bus.ula_sel, bus.ula_a, bus.ula_b, bus.cmd_ready);
    end
    wait_rsp(t, s, e, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL add_latency: got %0d expected 1", lat);
    end
    x = sb.pop_front();
    checks++;
    if ({s, e} !== {x.saida, x.err}) begin
      errors++; $display("FAIL add_rsp: got saida=%0b err=%0b expected %0b/%0b", s, e, x.saida, x.err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (op_cnt !== 8'd1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_op_count: got %0d v=%0b expected 1 v=0", op_cnt, bus.rsp_valid);
    end
  endtask

  task automatic test_carry_mismatch();
    logic [3:0] sels [2] = '{4'b0000, 4'b0010};
    logic [2:0] exps [2] = '{3'b100, 3'b000};
    logic [2:0] ress [2] = '{3'b100, 3'b011};
    logic       errs [2] = '{1'b0, 1'b1};
    int t, lat;
    logic [2:0] s;
    logic e;
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      send(sels[i], 2'b11, 2'b01, exps[i], 1'b1, ress[i], errs[i], t);
      wait_rsp(t, s, e, lat);
      x = sb.pop_front();
      checks++;
      if ({s, e} !== {x.saida, x.err}) begin
        errors++;
        $display("FAIL carry_mismatch_rsp%0d: got saida=%0b err=%0b expected %0b/%0b",
                 i, s, e, x.saida, x.err);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    checks++;
    if (op_cnt !== 8'd3 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL carry_mismatch_counts: got %0d/%0d expected 3/1", op_cnt, err_cnt);
    end
  endtask

  task automatic test_nochk();
    int t, lat;
    logic [2:0] s;
    logic e;
    exp_t x;
    send(4'b0000, 2'b01, 2'b00, 3'b111, 1'b0, 3'b001, 1'b0, t);
    wait_rsp(t, s, e, lat);
    x = sb.pop_front();
    checks++;
    if ({s, e} !== {x.saida, x.err}) begin
      errors++; $display("FAIL nochk_rsp: got saida=%0b err=%0b expected %0b/%0b", s, e, x.saida, x.err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (op_cnt !== 8'd4 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL nochk_counts: got %0d/%0d expected 4/1", op_cnt, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int t, lat;
    logic [2:0] s;
    logic e;
    logic [7:0] base;
    exp_t x;
    send(4'b0011, 2'b10, 2'b01, 3'b001, 1'b1, 3'b001, 1'b0, t);
    wait_rsp(t, s, e, lat);
    base = op_cnt;
    noise = 3'b101;
    bus.cmd_sel = 4'b1111; bus.cmd_a = 2'b00; bus.cmd_b = 2'b00; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_saida !== 3'b001 || bus.cmd_ready !== 1'b0 || op_cnt !== base) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b saida=%0b rdy=%0b ops=%0d expected 1/001/0/%0d",
                 i, bus.rsp_valid, bus.rsp_saida, bus.cmd_ready, op_cnt, base);
      end
    end
    s = bus.rsp_saida;
    e = bus.rsp_err;
    bus.cmd_valid = 1'b0;
    noise = 3'b000;
    bus.rsp_ready = 1'b1;
    tick();
    x = sb.pop_front();
    checks++;
    if ({s, e} !== {x.saida, x.err}) begin
      errors++; $display("FAIL bp_rsp: got saida=%0b err=%0b expected %0b/%0b", s, e, x.saida, x.err);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || op_cnt !== base + 8'd1) begin
      errors++; $display("FAIL bp_release: got v=%0b ops=%0d expected 0/%0d", bus.rsp_valid, op_cnt, base + 8'd1);
    end
    repeat (2) tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (op_cnt !== base + 8'd1 || bus.ula_sel !== 4'b0011) begin
      errors++;
      $display("FAIL bp_single_handshake: got ops=%0d sel=%0b expected %0d/0011",
               op_cnt, bus.ula_sel, base + 8'd1);
    end
  endtask

  task automatic test_back_to_back();
    int nresp = 0;
    logic [7:0] base = op_cnt;
    bus.cmd_sel = 4'b0000; bus.cmd_a = 2'b01; bus.cmd_b = 2'b01;
    bus.cmd_exp = 3'b010; bus.cmd_chk = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        nresp++;
        checks++;
        if (bus.rsp_saida !== 3'b010 || bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got saida=%0b err=%0b rdy=%0b expected 010/0/0",
                   nresp, bus.rsp_saida, bus.rsp_err, bus.cmd_ready);
        end
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    checks++;
    if (nresp !== 10 || op_cnt !== base + 8'd10 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d rsps ops=%0d errs=%0d expected 10/%0d/1",
               nresp, op_cnt, err_cnt, base + 8'd10);
    end
  endtask

  task automatic test_reset_midop();
    int t;
    send(4'b1110, 2'b11, 2'b10, 3'b000, 1'b1, 3'b000, 1'b0, t);
    rst = 1'b1;
    tick();
    sb.delete();
    checks++;
    if (bus.rsp_valid !== 1'b0 || {bus.ula_sel, bus.ula_a, bus.ula_b} !== 8'd0 ||
        op_cnt !== 8'd0 || err_cnt !== 8'd0 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got v=%0b ula=%0h ops=%0d errs=%0d rdy=%0b expected all 0",
               bus.rsp_valid, {bus.ula_sel, bus.ula_a, bus.ula_b}, op_cnt, err_cnt, bus.cmd_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midop_after_reset: got rdy=%0b v=%0b expected 1/0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_latency();
    int t, lat;
    bit ok = 1'b0;
    exp_t x;
    bus3.cmd_sel = 4'b0100; bus3.cmd_a = 2'b01; bus3.cmd_b = 2'b00;
    bus3.cmd_exp = 3'b010; bus3.cmd_chk = 1'b1; bus3.cmd_valid = 1'b1;
    t = cyc;
    for (int n = 0; n < 20; n++) begin
      if (bus3.cmd_ready === 1'b1) begin
        ok = 1'b1;
        tick();
        t = cyc;
        break;
      end
      tick();
    end
    bus3.cmd_valid = 1'b0;
    sb.push_back('{saida: 3'b010, err: 1'b0});
    for (int n = 0; n < 20; n++) begin
      if (bus3.rsp_valid === 1'b1) break;
      tick();
    end
    lat = cyc - t;
    checks++;
    if (!ok || lat !== 3) begin
      errors++; $display("FAIL lat3_latency: got accept=%0b lat=%0d expected 1/3", ok, lat);
    end
    x = sb.pop_front();
    checks++;
    if ({bus3.rsp_saida, bus3.rsp_err} !== {x.saida, x.err}) begin
      errors++;
      $display("FAIL lat3_rsp: got saida=%0b err=%0b expected %0b/%0b",
               bus3.rsp_saida, bus3.rsp_err, x.saida, x.err);
    end
    bus3.rsp_ready = 1'b1;
    tick();
    bus3.rsp_ready = 1'b0;
    checks++;
    if (op_cnt3 !== 8'd1 || err_cnt3 !== 8'd0) begin
      errors++; $display("FAIL lat3_counts: got %0d/%0d expected 1/0", op_cnt3, err_cnt3);
    end
  endtask

  task automatic test_saturation();
    exp_t x;
    bit ok;
    int exp_n;
    bus2.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.cmd_sel = 4'b0000; bus2.cmd_a = 2'b01; bus2.cmd_b = 2'b01;
      bus2.cmd_exp = 3'b111; bus2.cmd_chk = 1'b1; bus2.cmd_valid = 1'b1;
      sb.push_back('{saida: 3'b010, err: 1'b1});
      for (int n = 0; n < 20; n++) begin
        if (bus2.cmd_ready === 1'b1) begin
          tick();
          break;
        end
        tick();
      end
      bus2.cmd_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        if (bus2.rsp_valid === 1'b1) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      x = sb.pop_front();
      checks++;
      if (!ok || {bus2.rsp_saida, bus2.rsp_err} !== {x.saida, x.err}) begin
        errors++;
        $display("FAIL sat_rsp%0d: got v=%0b saida=%0b err=%0b expected 1/%0b/%0b",
                 i, ok, bus2.rsp_saida, bus2.rsp_err, x.saida, x.err);
      end
      tick();
      exp_n = (i + 1 > 3) ? 3 : i + 1;
      checks++;
      if (int'(op_cnt2) !== exp_n || int'(err_cnt2) !== exp_n) begin
        errors++;
        $display("FAIL sat_counts%0d: got %0d/%0d expected %0d/%0d", i, op_cnt2, err_cnt2, exp_n, exp_n);
      end
    end
    bus2.rsp_ready = 1'b0;
  endtask

  initial begin
    noise = 3'b000;
    bus.cmd_valid = 1'b0;  bus.rsp_ready = 1'b0;  bus.cmd_sel = 4'd0;  bus.cmd_a = 2'd0;
    bus.cmd_b = 2'd0;  bus.cmd_exp = 3'd0;  bus.cmd_chk = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.rsp_ready = 1'b0; bus3.cmd_sel = 4'd0; bus3.cmd_a = 2'd0;
    bus3.cmd_b = 2'd0; bus3.cmd_exp = 3'd0; bus3.cmd_chk = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.rsp_ready = 1'b0; bus2.cmd_sel = 4'd0; bus2.cmd_a = 2'd0;
    bus2.cmd_b = 2'd0; bus2.cmd_exp = 3'd0; bus2.cmd_chk = 1'b0;
    test_reset();
    test_add();
    test_carry_mismatch();
    test_nochk();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_latency();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
